// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation station slice.
// The reserved ID value marks "no producer"; broadcasts carrying it never wake anything.
package reservation_station_pkg;

    localparam int RS_ID_NONE = 0;

    typedef struct packed {
        logic       subtract;
        logic       with_carry;
        logic [4:0] dest_reg;
    } add_sub_decode_t;

endpackage

// File: rtl/reservation_station_rs_age_select.sv
// Age matrix for the reservation station: remembers relative allocation order
// and picks the oldest entry among those currently ready to issue.
module rs_age_select
    import reservation_station_pkg::*;
#(
    parameter int RS_DEPTH = 4,
    localparam int IDX_W   = $clog2(RS_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_en,
    input  logic [IDX_W-1:0]    alloc_idx,
    input  logic [RS_DEPTH-1:0] occupied,
    input  logic [RS_DEPTH-1:0] ready,
    output logic [RS_DEPTH-1:0] oldest_onehot,
    output logic [IDX_W-1:0]    oldest_idx
);

    // age_q[i][j] set means entry j was allocated before entry i
    logic [RS_DEPTH-1:0] age_q [RS_DEPTH];
    logic [RS_DEPTH-1:0] age_d [RS_DEPTH];

    always_comb begin
        age_d = age_q;
        if (alloc_en) begin
            for (int r = 0; r < RS_DEPTH; r++) begin
                age_d[r][alloc_idx] = 1'b0;
            end
            age_d[alloc_idx] = occupied;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < RS_DEPTH; r++) begin
                age_q[r] <= '0;
            end
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        oldest_onehot = '0;
        oldest_idx    = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            oldest_onehot[i] = ready[i] && ((age_q[i] & ready) == '0);
            if (oldest_onehot[i]) begin
                oldest_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched operations, snoops the result bus for
// missing operands and hands the oldest ready operation to its execution unit.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int  RS_ID_WIDTH = 5,
    parameter int  RS_DEPTH    = 4,
    parameter int  UNIT_ID     = 1,
    parameter type OPCODE_TYPE = add_sub_decode_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  OPCODE_TYPE             decode,
    output logic [RS_ID_WIDTH-1:0] id_taken,
    input  logic                   op1_valid,
    input  logic [31:0]            op1_value,
    input  logic [RS_ID_WIDTH-1:0] op1_rs_id,
    input  logic                   op2_valid,
    input  logic [31:0]            op2_value,
    input  logic [RS_ID_WIDTH-1:0] op2_rs_id,
    input  logic                   result_valid,
    input  logic [RS_ID_WIDTH-1:0] result_rs_id,
    input  logic [31:0]            result_value,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output OPCODE_TYPE             issue_decode,
    output logic [31:0]            issue_op1,
    output logic [31:0]            issue_op2,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int UID_W = RS_ID_WIDTH - IDX_W;
    localparam logic [UID_W-1:0] UNIT_PREFIX = UID_W'(UNIT_ID);

    // Entry layout depends on OPCODE_TYPE, so it is declared per instance.
    typedef struct packed {
        OPCODE_TYPE             decode;
        logic [31:0]            op1_value;
        logic [31:0]            op2_value;
        logic                   op1_ready;
        logic                   op2_ready;
        logic [RS_ID_WIDTH-1:0] op1_tag;
        logic [RS_ID_WIDTH-1:0] op2_tag;
    } rs_entry_t;

    rs_entry_t           entry_q [RS_DEPTH];
    rs_entry_t           entry_d [RS_DEPTH];
    logic [RS_DEPTH-1:0] valid_q, valid_d;
    logic                lock_valid_q, lock_valid_d;
    logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;

    logic [IDX_W-1:0]    free_idx, oldest_idx, sel_idx;
    logic [RS_DEPTH-1:0] ready_vec, oldest_onehot;
    logic                alloc, handshake, snoop_en;
    rs_entry_t           new_entry;

    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready_vec[i] = valid_q[i] && entry_q[i].op1_ready && entry_q[i].op2_ready;
        end
    end

    rs_age_select #(.RS_DEPTH(RS_DEPTH)) u_age_select (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_en      (alloc),
        .alloc_idx     (free_idx),
        .occupied      (valid_q),
        .ready         (ready_vec),
        .oldest_onehot (oldest_onehot),
        .oldest_idx    (oldest_idx)
    );

    assign input_ready = ~&valid_q;
    assign id_taken    = {UNIT_PREFIX, free_idx};
    assign alloc       = input_valid && input_ready;
    assign snoop_en    = result_valid && (result_rs_id != RS_ID_WIDTH'(RS_ID_NONE));

    // A locked selection overrides the age pick so the unit sees stable outputs.
    assign sel_idx      = lock_valid_q ? lock_idx_q : oldest_idx;
    assign issue_valid  = lock_valid_q || (|oldest_onehot);
    assign handshake    = issue_valid && issue_ready;
    assign issue_decode = issue_valid ? entry_q[sel_idx].decode : '0;
    assign issue_op1    = issue_valid ? entry_q[sel_idx].op1_value : '0;
    assign issue_op2    = issue_valid ? entry_q[sel_idx].op2_value : '0;
    assign issue_rs_id  = issue_valid ? {UNIT_PREFIX, sel_idx} : '0;

    always_comb begin
        new_entry           = '0;
        new_entry.decode    = decode;
        new_entry.op1_tag   = op1_rs_id;
        new_entry.op2_tag   = op2_rs_id;
        if (op1_valid) begin
            new_entry.op1_value = op1_value;
            new_entry.op1_ready = 1'b1;
        end else if (snoop_en && (result_rs_id == op1_rs_id)) begin
            new_entry.op1_value = result_value;
            new_entry.op1_ready = 1'b1;
        end
        if (op2_valid) begin
            new_entry.op2_value = op2_value;
            new_entry.op2_ready = 1'b1;
        end else if (snoop_en && (result_rs_id == op2_rs_id)) begin
            new_entry.op2_value = result_value;
            new_entry.op2_ready = 1'b1;
        end
    end

    always_comb begin
        entry_d      = entry_q;
        valid_d      = valid_q;
        lock_valid_d = lock_valid_q;
        lock_idx_d   = lock_idx_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (valid_q[i] && snoop_en) begin
                if (!entry_q[i].op1_ready && (entry_q[i].op1_tag == result_rs_id)) begin
                    entry_d[i].op1_value = result_value;
                    entry_d[i].op1_ready = 1'b1;
                end
                if (!entry_q[i].op2_ready && (entry_q[i].op2_tag == result_rs_id)) begin
                    entry_d[i].op2_value = result_value;
                    entry_d[i].op2_ready = 1'b1;
                end
            end
        end
        if (handshake) begin
            valid_d[sel_idx] = 1'b0;
            lock_valid_d     = 1'b0;
        end else if (issue_valid) begin
            lock_valid_d = 1'b1;
            lock_idx_d   = sel_idx;
        end
        // free_idx only ever names an entry that was empty before this edge
        if (alloc) begin
            valid_d[free_idx] = 1'b1;
            entry_d[free_idx] = new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
        end else begin
            entry_q      <= entry_d;
            valid_q      <= valid_d;
            lock_valid_q <= lock_valid_d;
            lock_idx_q   <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios followed by
// random traffic, all compared every cycle against a sequence-number based model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int W   = 5;
    localparam int D   = 4;
    localparam int UID = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            input_valid;
    logic            input_ready;
    add_sub_decode_t decode;
    logic [W-1:0]    id_taken;
    logic            op1_valid, op2_valid;
    logic [31:0]     op1_value, op2_value;
    logic [W-1:0]    op1_rs_id, op2_rs_id;
    logic            result_valid;
    logic [W-1:0]    result_rs_id;
    logic [31:0]     result_value;
    logic            issue_valid;
    logic            issue_ready;
    add_sub_decode_t issue_decode;
    logic [31:0]     issue_op1, issue_op2;
    logic [W-1:0]    issue_rs_id;

    always #5 clk = ~clk;

    reservation_station #(
        .RS_ID_WIDTH (W),
        .RS_DEPTH    (D),
        .UNIT_ID     (UID),
        .OPCODE_TYPE (add_sub_decode_t)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .decode       (decode),
        .id_taken     (id_taken),
        .op1_valid    (op1_valid),
        .op1_value    (op1_value),
        .op1_rs_id    (op1_rs_id),
        .op2_valid    (op2_valid),
        .op2_value    (op2_value),
        .op2_rs_id    (op2_rs_id),
        .result_valid (result_valid),
        .result_rs_id (result_rs_id),
        .result_value (result_value),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_decode (issue_decode),
        .issue_op1    (issue_op1),
        .issue_op2    (issue_op2),
        .issue_rs_id  (issue_rs_id)
    );

    // Model: each held operation carries an allocation sequence number; oldest = smallest.
    bit              m_occ [D];
    int unsigned     m_seq_of [D];
    bit              m_r1 [D], m_r2 [D];
    logic [31:0]     m_v1 [D], m_v2 [D];
    logic [W-1:0]    m_t1 [D], m_t2 [D];
    add_sub_decode_t m_dec [D];
    bit              m_locked;
    int              m_lock;
    int unsigned     m_seq;

    bit              e_ready, e_ivalid;
    int              e_free, e_sel;

    int checks   = 0;
    int failures = 0;

    function automatic logic [W-1:0] mkId(input int idx);
        return W'(UID * D + idx);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
            $error("[TB] check %s disagreed", tag);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < D; i++) begin
            m_occ[i] = 1'b0;
            m_r1[i]  = 1'b0;
            m_r2[i]  = 1'b0;
        end
        m_locked = 1'b0;
        m_lock   = 0;
        m_seq    = 0;
    endtask

    task automatic computeExpected();
        e_free = -1;
        for (int i = 0; i < D; i++) begin
            if (!m_occ[i] && e_free < 0) e_free = i;
        end
        e_ready = (e_free >= 0);
        if (m_locked) begin
            e_sel = m_lock;
        end else begin
            e_sel = -1;
            for (int i = 0; i < D; i++) begin
                if (m_occ[i] && m_r1[i] && m_r2[i] &&
                    (e_sel < 0 || m_seq_of[i] < m_seq_of[e_sel])) e_sel = i;
            end
        end
        e_ivalid = (e_sel >= 0);
    endtask

    task automatic checkAll();
        computeExpected();
        checkOutput("input_ready", 64'(input_ready), 64'(e_ready));
        checkOutput("id_taken", 64'(id_taken), 64'(mkId(e_free < 0 ? 0 : e_free)));
        checkOutput("issue_valid", 64'(issue_valid), 64'(e_ivalid));
        checkOutput("issue_rs_id", 64'(issue_rs_id), e_ivalid ? 64'(mkId(e_sel)) : 64'd0);
        checkOutput("issue_op1", 64'(issue_op1), e_ivalid ? 64'(m_v1[e_sel]) : 64'd0);
        checkOutput("issue_op2", 64'(issue_op2), e_ivalid ? 64'(m_v2[e_sel]) : 64'd0);
        checkOutput("issue_decode", 64'(issue_decode), e_ivalid ? 64'(m_dec[e_sel]) : 64'd0);
    endtask

    task automatic modelEdge();
        bit hs, al;
        hs = e_ivalid && issue_ready;
        al = input_valid && e_ready;
        if (result_valid) begin
            for (int i = 0; i < D; i++) begin
                if (m_occ[i] && !m_r1[i] && m_t1[i] == result_rs_id) begin
                    m_r1[i] = 1'b1;
                    m_v1[i] = result_value;
                end
                if (m_occ[i] && !m_r2[i] && m_t2[i] == result_rs_id) begin
                    m_r2[i] = 1'b1;
                    m_v2[i] = result_value;
                end
            end
        end
        if (hs) begin
            m_occ[e_sel] = 1'b0;
            m_locked     = 1'b0;
        end else if (e_ivalid) begin
            m_locked = 1'b1;
            m_lock   = e_sel;
        end
        if (al) begin
            m_occ[e_free]    = 1'b1;
            m_seq_of[e_free] = m_seq;
            m_seq++;
            m_dec[e_free] = decode;
            m_t1[e_free]  = op1_rs_id;
            m_t2[e_free]  = op2_rs_id;
            m_r1[e_free]  = op1_valid || (result_valid && result_rs_id == op1_rs_id);
            m_r2[e_free]  = op2_valid || (result_valid && result_rs_id == op2_rs_id);
            m_v1[e_free]  = op1_valid ? op1_value : result_value;
            m_v2[e_free]  = op2_valid ? op2_value : result_value;
        end
    endtask

    task automatic stepCycle();
        checkAll();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit iv,
                                 input bit o1v, input logic [31:0] o1val, input logic [W-1:0] o1tag,
                                 input bit o2v, input logic [31:0] o2val, input logic [W-1:0] o2tag,
                                 input bit rv, input logic [W-1:0] rtag, input logic [31:0] rval,
                                 input bit ir);
        logic [$bits(add_sub_decode_t)-1:0] dbits;
        dbits        = $bits(add_sub_decode_t)'($urandom);
        input_valid  = iv;
        decode       = dbits;
        op1_valid    = o1v;
        op1_value    = o1val;
        op1_rs_id    = o1tag;
        op2_valid    = o2v;
        op2_value    = o2val;
        op2_rs_id    = o2tag;
        result_valid = rv;
        result_rs_id = rtag;
        result_value = rval;
        issue_ready  = ir;
    endtask

    task automatic idle(input bit ir);
        applyStimulus(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 32'd0, ir);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1'b0);
        modelReset();
        #12;
        checkOutput("reset_input_ready", 64'(input_ready), 64'd1);
        checkOutput("reset_issue_valid", 64'(issue_valid), 64'd0);
        checkOutput("reset_id_taken", 64'(id_taken), 64'd4);
        checkOutput("reset_issue_rs_id", 64'(issue_rs_id), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Both operands present: issued the cycle after allocation
        applyStimulus(1'b1, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        checkOutput("t1_id_taken", 64'(id_taken), 64'd4);
        stepCycle();
        idle(1'b1);
        checkOutput("t1_issue_valid", 64'(issue_valid), 64'd1);
        checkOutput("t1_issue_op1", 64'(issue_op1), 64'd5);
        checkOutput("t1_issue_op2", 64'(issue_op2), 64'd7);
        checkOutput("t1_issue_rs_id", 64'(issue_rs_id), 64'd4);
        stepCycle();
        stepCycle();
        checkOutput("t1_freed", 64'(issue_valid), 64'd0);

        // op1 waits on tag 9, broadcast three cycles later
        applyStimulus(1'b1, 1'b0, 32'd0, 5'd9, 1'b1, 32'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        stepCycle();
        idle(1'b1);
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b1, 5'd9, 32'hDEADBEEF, 1'b1);
        checkOutput("t2_no_early_issue", 64'(issue_valid), 64'd0);
        stepCycle();
        idle(1'b1);
        checkOutput("t2_issue_op1", 64'(issue_op1), 64'hDEADBEEF);
        stepCycle();

        // Same-cycle forward of op2
        applyStimulus(1'b1, 1'b1, 32'd11, 5'd0, 1'b0, 32'd0, 5'd9, 1'b1, 5'd9, 32'h1234, 1'b1);
        stepCycle();
        idle(1'b1);
        checkOutput("t3_issue_valid", 64'(issue_valid), 64'd1);
        checkOutput("t3_issue_op2", 64'(issue_op2), 64'h1234);
        stepCycle();

        // Fill all entries with the unit stalled
        for (int k = 0; k < D; k++) begin
            applyStimulus(1'b1, 1'b1, 32'(100 + k), 5'd0, 1'b1, 32'(200 + k), 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
            stepCycle();
        end
        checkOutput("t4_full", 64'(input_ready), 64'd0);
        applyStimulus(1'b1, 1'b1, 32'd999, 5'd0, 1'b1, 32'd999, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        stepCycle();
        idle(1'b1);
        stepCycle();
        idle(1'b0);
        checkOutput("t4_ready_again", 64'(input_ready), 64'd1);
        checkOutput("t4_id_freed", 64'(id_taken), 64'd4);
        idle(1'b1);
        for (int k = 0; k < 6; k++) stepCycle();

        // Older waiter A, younger ready B: B stays locked until handshake
        applyStimulus(1'b1, 1'b0, 32'd0, 5'd10, 1'b1, 32'd1, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 32'd2, 5'd0, 1'b1, 32'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        stepCycle();
        idle(1'b0);
        checkOutput("t5_b_presented", 64'(issue_rs_id), 64'd5);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b1, 5'd10, 32'h55AA, 1'b0);
        stepCycle();
        idle(1'b1);
        checkOutput("t5_b_still_locked", 64'(issue_rs_id), 64'd5);
        stepCycle();
        checkOutput("t5_a_issued", 64'(issue_rs_id), 64'd4);
        checkOutput("t5_a_op1", 64'(issue_op1), 64'h55AA);
        stepCycle();

        // Asynchronous reset with three held operations
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 32'(k), 5'd0, 1'b1, 32'(k), 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
            stepCycle();
        end
        idle(1'b0);
        checkOutput("t6_pre_reset_valid", 64'(issue_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_async_issue_valid", 64'(issue_valid), 64'd0);
        checkOutput("t6_async_input_ready", 64'(input_ready), 64'd1);
        checkOutput("t6_async_issue_rs_id", 64'(issue_rs_id), 64'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        for (int k = 0; k < 3; k++) stepCycle();

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            applyStimulus(1'($urandom_range(0, 9) < 6),
                          1'($urandom_range(0, 1)), $urandom, W'($urandom_range(8, 15)),
                          1'($urandom_range(0, 1)), $urandom, W'($urandom_range(8, 15)),
                          1'($urandom_range(0, 1)), W'($urandom_range(8, 15)), $urandom,
                          1'($urandom_range(0, 2) != 0));
            stepCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Per-execution-unit operand buffer sitting directly downstream of the dispatcher.
- Accepts one decoded operation per cycle, together with its operands. Each operand arrives either as a value or as the RS ID of the producing operation.
- Snoops the result bus for missing operands and issues the oldest fully-ready operation to its execution unit.
- Supplies the dispatcher with the RS ID the next allocation will receive. One instance per unit: add_sub, mul, div, log, rot, cmp, trap, sys, load_store.

Parameters:
- RS_ID_WIDTH, 5: width of RS IDs (tag space shared by all stations).
- RS_DEPTH, 4: number of entries; power of two, at least 2.
- UNIT_ID, 1: upper RS_ID_WIDTH-$clog2(RS_DEPTH) ID bits for this station; nonzero, because ID 0 is reserved for "no producer / invalid".
- OPCODE_TYPE, add_sub_decode_t: type parameter for the unit's decode struct.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- input_valid  in  1  dispatch request
- input_ready  out  1  at least one free entry
- decode  in  OPCODE_TYPE  operation to store
- id_taken  out  RS_ID_WIDTH  ID assigned to this cycle's allocation, {UNIT_ID, free index}
- op1_valid / op2_valid  in  1  operand value present
- op1_value / op2_value  in  32  operand value
- op1_rs_id / op2_rs_id  in  RS_ID_WIDTH  producer ID when the matching opN_valid=0
- result_valid  in  1  result bus broadcast
- result_rs_id  in  RS_ID_WIDTH  producer ID of the broadcast
- result_value  in  32  broadcast value
- issue_valid  out  1  operation presented to the unit
- issue_ready  in  1  unit accepts
- issue_decode  out  OPCODE_TYPE  stored decode
- issue_op1 / issue_op2  out  32  resolved operands
- issue_rs_id  out  RS_ID_WIDTH  ID of the issued entry; the unit tags its result with it

Behaviour:
- Reset, asynchronous, rst_n=0:
  - All entries are freed, the age matrix is cleared and the issue lock is cleared.
  - issue_valid=0 and input_ready=1. id_taken={UNIT_ID,0}; issue_rs_id and all data outputs are 0.
  - Reset mid-operation discards every held operation without issuing it.
- Allocation:
  - input_ready=|free, derived from registered state only.
  - The free index is the lowest free entry, and id_taken always reflects it, regardless of input_valid.
  - On input_valid&&input_ready the entry is written at the clock edge.
  - Each operand is stored as ready if opN_valid=1. Otherwise, if result_valid and result_rs_id==opN_rs_id in the same cycle, result_value is captured as ready (same-cycle forward). Otherwise the entry waits on opN_rs_id.
  - input_valid while full is ignored and the dispatcher stalls.
- Snoop: every cycle, each occupied entry with a waiting operand whose tag equals result_rs_id, while result_valid=1, captures result_value and marks that operand ready. Both operands of one entry may capture the same broadcast.
- Age:
  - RS_DEPTH x RS_DEPTH age matrix. On allocation of entry i, row i is set to the current occupancy (i is younger than every current entry) and column i is cleared.
  - The oldest ready entry is the ready entry with no older ready entry.
- Issue:
  - Zero-latency: an entry made ready at edge N may be presented in cycle N.
  - When issue_valid is 0 and some entry is ready, the oldest ready entry is selected combinationally and issue_valid rises.
  - If issue_ready=0, the selected index is locked in a register at the edge. issue_valid and all issue_* outputs then stay stable until handshake, even if an older entry becomes ready meanwhile.
  - On issue_valid&&issue_ready the entry is freed at the edge and the lock is cleared.
  - A freed entry is not reallocatable in the same cycle; it appears in input_ready the next cycle.
- Simultaneous events:
  - Allocation and issue handshake in the same cycle touch different entries and are both performed.
  - A snoop and an allocation in the same cycle are both applied, including the forward path.
  - An entry allocated this cycle is never selected for issue this cycle.
- A result broadcast with an ID matching no waiter is ignored.

Decomposition:
- ppc_types gains:
  - rs_entry_t: decode, op1/op2 value, op1/op2 ready, op1/op2 tag.
  - The reserved constant RS_ID_NONE=0.
- One natural submodule: rs_age_select. It holds the age matrix and produces the oldest-ready one-hot and index.
- Everything else is in reservation_station.

Test Plan:
- Reset, then an allocation with both operands valid (op1=5, op2=7), issue_ready=1 → id_taken={UNIT_ID,0}; next cycle issue_valid=1, issue_op1=5, issue_op2=7, issue_rs_id={UNIT_ID,0}; entry freed.
- Allocation with op1 waiting on tag 9; result_valid with tag 9, value 0xDEADBEEF, three cycles later → no issue before the broadcast; issue the cycle after, with issue_op1=0xDEADBEEF.
- Allocation with op2 tag 9 and a tag-9 broadcast in the same cycle → operand captured via forward; issue next cycle.
- Fill RS_DEPTH=4 entries with issue_ready=0 → input_ready=0 after the 4th allocation; the 5th request is not accepted; after one handshake, input_ready=1 one cycle later and id_taken=the freed index.
- Entries A (older, waiting) and B (ready), issue_ready=0 → B presented and locked; A becomes ready → outputs still show B until handshake, then A issues.
- Assert rst_n=0 with 3 entries occupied and issue_valid=1 → issue_valid=0 immediately (asynchronous); input_ready=1; no stale issue after release.
